// File: rtl/core_pkg.sv
// Shared core definitions: the memory-arbiter state encoding and the default
// bus widths. The controller and datapath use the same constants.
package core_pkg;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 16;

  // Arbiter states. BUSY_x means an access is in flight for port x.
  // DONE_x is the single cycle that carries x's completion pulse.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_I = 3'd1,
    BUSY_D = 3'd2,
    DONE_I = 3'd3,
    DONE_D = 3'd4
  } arbState_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear. It reports when the count
// equals LIMIT and holds there until cleared.
module sat_counter #(
  parameter int WIDTH = 4,
  parameter int LIMIT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic atLimit
);

  localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);

  logic [WIDTH-1:0] count;

  // Count register: clear wins over increment; increments stop at LIM.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != LIM)) begin
      count <= count + 1'b1;
    end
  end

  assign atLimit = (count == LIM);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port memory between instruction fetch and load/store.
// It drives the memory from registered copies of the granted request, waits
// on m_ready, prevents fetch starvation, and aborts hung accesses. An abort
// sets a sticky err flag that only reset clears.
module mem_port_arbiter
  import core_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_LIM = 3,
  parameter int TIMEOUT    = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ready,
  output logic              stall,
  output logic              err
);

  arbState_e state, stateNext;

  logic grantI, grantD;        // grant issued this cycle (only in IDLE)
  logic accessEnd, timedOut;   // BUSY ends this cycle, and whether by abort
  logic starveInc, starveClr;
  logic toInc, toClr;
  logic starveAtLimit, toAtLimit;

  // Counts simultaneous arbitrations that fetch lost.
  sat_counter #(
    .WIDTH (4),
    .LIMIT (STARVE_LIM)
  ) u_starve (
    .clk     (clk),
    .rst     (rst),
    .clr     (starveClr),
    .inc     (starveInc),
    .atLimit (starveAtLimit)
  );

  // Counts BUSY cycles without m_ready. The limit is one below TIMEOUT because
  // the abort happens in the cycle that would make the count reach TIMEOUT.
  // That gives exactly TIMEOUT BUSY cycles before DONE.
  sat_counter #(
    .WIDTH (8),
    .LIMIT (TIMEOUT - 1)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (toClr),
    .inc     (toInc),
    .atLimit (toAtLimit)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic: arbitration in IDLE, completion or abort in BUSY.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    stateNext = state;
    grantI    = 1'b0;
    grantD    = 1'b0;
    accessEnd = 1'b0;
    timedOut  = 1'b0;
    starveInc = 1'b0;
    toInc     = 1'b0;
    case (state)
      IDLE: begin
        if (if_req && (!d_req || starveAtLimit)) begin
          grantI    = 1'b1;
          stateNext = BUSY_I;
        end else if (d_req) begin
          grantD    = 1'b1;
          starveInc = if_req;
          stateNext = BUSY_D;
        end
      end
      BUSY_I, BUSY_D: begin
        if (m_ready) begin
          accessEnd = 1'b1;
        end else if (toAtLimit) begin
          accessEnd = 1'b1;
          timedOut  = 1'b1;
        end else begin
          toInc = 1'b1;
        end
        if (accessEnd) begin
          stateNext = (state == BUSY_I) ? DONE_I : DONE_D;
        end
      end
      DONE_I, DONE_D: stateNext = IDLE;
      default:        stateNext = IDLE;
    endcase
  end

  assign starveClr = grantI;
  assign toClr     = grantI | grantD;

  // Registered memory-side fields, read data, done pulses and sticky error.
  always_ff @(posedge clk) begin
    if (!rst) begin
      m_en     <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      if_rdata <= '0;
      d_rdata  <= '0;
      if_done  <= 1'b0;
      d_done   <= 1'b0;
      err      <= 1'b0;
    end else begin
      if_done <= 1'b0;
      d_done  <= 1'b0;
      if (grantI) begin
        m_en   <= 1'b1;
        m_we   <= 1'b0;
        m_addr <= if_addr;
      end else if (grantD) begin
        m_en    <= 1'b1;
        m_we    <= d_we;
        m_addr  <= d_addr;
        m_wdata <= d_wdata;
      end else if (accessEnd) begin
        m_en <= 1'b0;
        m_we <= 1'b0;
        if (timedOut) begin
          err <= 1'b1;
        end
        if (state == BUSY_I) begin
          if_done  <= 1'b1;
          if_rdata <= timedOut ? '0 : m_rdata;
        end else begin
          d_done <= 1'b1;
          if (timedOut) begin
            d_rdata <= '0;
          end else if (!m_we) begin
            d_rdata <= m_rdata;
          end
        end
      end
    end
  end

  // The core holds while any request is outstanding and not completing now.
  assign stall = (if_req & ~if_done) | (d_req & ~d_done);

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port data/instruction memory between the instruction-fetch path and the load/store path of the 16-bit MIPS core. It grants one requester at a time and drives the memory with latched request fields. It handles variable memory latency through a ready handshake, prevents fetch starvation, and aborts hung accesses with a sticky error. It sits between the PC/fetch logic, the datapath's memRead/memWrite path, and the memory, and produces the stall used to freeze PC and the register window.

## Interface
- ADDR_W, 12, memory word-address width
- DATA_W, 16, data/instruction width
- STARVE_LIM, 3, consecutive fetch losses before fetch gets priority (1..15)
- TIMEOUT, 15, max BUSY cycles waiting for m_ready before abort (1..255)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset (one clock; sampled on rising clk edge)
- if_req  in  1  fetch request, held until if_done
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched instruction, valid when if_done
- if_done  out  1  one-cycle fetch completion pulse
- d_req  in  1  load/store request, held until d_done
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data, valid when d_done
- d_done  out  1  one-cycle data completion pulse
- m_en  out  1  memory access active
- m_we  out  1  memory write enable
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_rdata  in  DATA_W  memory read data, valid with m_ready
- m_ready  in  1  memory completes the current access this cycle
- stall  out  1  core must hold PC/pipeline state
- err  out  1  sticky timeout flag

## Operation
- States: IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D.
- IDLE: if only one req is high, grant it. If both are high, grant data, unless the starve counter has reached STARVE_LIM; in that case grant fetch. On grant, latch addr/we/wdata into output registers (fetch forces we=0) and go to BUSY_x.
- BUSY_x: m_en=1, m_we=latched we. On m_ready: capture m_rdata into the x rdata register (loads/fetch only; stores leave it unchanged) and go to DONE_x. If the timeout counter reaches TIMEOUT without m_ready: set err, set rdata to 0, go to DONE_x.
- DONE_x: x_done=1 for exactly this cycle, m_en=0, then IDLE. The requester drops req in the cycle after done. A req still high in IDLE is treated as a new request.
- Starve counter: increments when fetch loses a simultaneous arbitration, saturating at STARVE_LIM. Clears on any fetch grant.
- Timeout counter: clears on entering BUSY_x and increments each BUSY cycle without m_ready.
- Request inputs that change while BUSY have no effect; the latched fields are used.
- stall = (if_req & ~if_done) | (d_req & ~d_done), combinational.
- err clears only on reset.

## Timing
- Reset (rst=0 at an edge): state IDLE; m_en, m_we, m_addr, m_wdata, if_rdata, d_rdata, if_done, d_done, err and both counters are 0. stall stays combinational from req.
- Reset asserted mid-access abandons the access. No done pulse is issued.
- Minimum latency is 3 cycles from req sampled in IDLE to done: grant edge, then BUSY with m_ready=1, then DONE. Each extra cycle of m_ready latency adds 1.
- Back-to-back service: DONE is followed by IDLE, and a waiting requester is granted at that IDLE edge. Per-access throughput is therefore at least 3 cycles.
- m_ready outside BUSY is ignored.
- Outputs m_* are registered, not combinational from inputs.

## Structure
- Shared package core_pkg: the state enum (IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D) and the default ADDR_W/DATA_W constants, shared with controller and datapath.
- One natural sub-module: sat_counter, a parameterised width/limit counter with clear, increment and at_limit outputs. It is instantiated twice, for starve and timeout.

## Test plan
- Single fetch: if_req=1, if_addr=0x010, m_ready in the first BUSY cycle, m_rdata=0x1234. Expect m_en for 1 cycle with m_addr=0x010, then if_done with if_rdata=0x1234 at cycle 3. stall=1 from req until done.
- Contention: both reqs held continuously, with m_ready immediate and the requester re-asserting req after each done. Expect data granted 3 times and fetch granted on the 4th arbitration; the starve counter then clears.
- Store with wait states: d_req, d_we=1, d_addr=0x2A, d_wdata=0xBEEF, m_ready after 4 BUSY cycles. Expect m_we=1 and m_wdata=0xBEEF held stable for all 4 cycles, then d_done. d_rdata is unchanged.
- Timeout: d_req load, m_ready never asserted. Expect 15 BUSY cycles, then d_done with d_rdata=0. err=1 stays set through later successful accesses until rst=0.
- Reset mid-access: rst=0 during BUSY_I. Expect at the next edge m_en=0, no if_done, err=0 and state IDLE. After rst=1 with if_req high, a fresh fetch is granted.
- Input change while busy: alter d_addr during BUSY_D. m_addr must keep the granted value.
